// File: rtl/memory_controller_if.sv
// Bus bundle between the memory controller, the byte-wide RAM, the load/store
// buffer and the instruction fetch unit.
interface memory_controller_if #(
    parameter int ADDR_W = 32
);
    // Handshakes: lsb_flag is a one-cycle request pulse that may only be raised
    // while lsb_enable was high the cycle before; data_rdy answers it with one
    // pulse. if_flag is held high until the one-cycle inst_rdy pulse. Nothing
    // moves while rdy is low.
    logic              rdy;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;
    logic              lsb_flag;
    logic              lsb_r_nw;
    logic              load_sign;
    logic [1:0]        data_size_to_mc;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_write;
    logic [31:0]       data_read;
    logic              lsb_enable;
    logic              data_rdy;
    logic              if_flag;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       inst;
    logic              inst_rdy;
    logic              lsb_flush;

    modport slave (
        input  rdy, mem_din, io_buffer_full, lsb_flag, lsb_r_nw, load_sign,
               data_size_to_mc, data_addr, data_write, if_flag, if_addr, lsb_flush,
        output mem_dout, mem_a, mem_wr, data_read, lsb_enable, data_rdy, inst, inst_rdy
    );

    modport master (
        output rdy, mem_din, io_buffer_full, lsb_flag, lsb_r_nw, load_sign,
               data_size_to_mc, data_addr, data_write, if_flag, if_addr, lsb_flush,
        input  mem_dout, mem_a, mem_wr, data_read, lsb_enable, data_rdy, inst, inst_rdy
    );
endinterface

// File: rtl/memory_controller.sv
// Arbitrates fetch and load/store requests onto a single-port byte-wide RAM,
// serialising each request into byte accesses and reassembling read data.
module memory_controller #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11,
    parameter int         ADDR_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    memory_controller_if.slave bus,
    output logic [2:0]         dbg_state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IF_RD   = 3'd1,
        LS_RD   = 3'd2,
        LS_WR   = 3'd3,
        IO_WAIT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d, n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, rbuf_q, rbuf_d;
    logic              sign_q, sign_d;
    logic [1:0]        size_q, size_d;

    logic              pend_v_q, pend_v_d, pend_rnw_q, pend_rnw_d, pend_sign_q, pend_sign_d;
    logic [1:0]        pend_size_q, pend_size_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [31:0]       pend_data_q, pend_data_d;

    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic [31:0]       data_read_q, data_read_d, inst_q, inst_d;
    logic              data_rdy_q, data_rdy_d, inst_rdy_q, inst_rdy_d;

    logic              req_rnw, req_sign;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic              use_pend, if_go, direct_take, ls_go;
    logic [2:0]        cnt_inc;
    logic [31:0]       asm_word, ext_word;

    function automatic logic [2:0] size_to_n(input logic [1:0] s);
        case (s)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // A buffered request always wins; a fresh pulse is taken directly only
    // when the buffer is empty and no fetch is starting this edge.
    always_comb begin
        req_rnw     = pend_v_q ? pend_rnw_q  : bus.lsb_r_nw;
        req_sign    = pend_v_q ? pend_sign_q : bus.load_sign;
        req_size    = pend_v_q ? pend_size_q : bus.data_size_to_mc;
        req_addr    = pend_v_q ? pend_addr_q : bus.data_addr;
        req_data    = pend_v_q ? pend_data_q : bus.data_write;
        use_pend    = pend_v_q && !(bus.lsb_flush && pend_rnw_q);
        if_go       = !pend_v_q && bus.if_flag && !bus.lsb_flush;
        direct_take = !pend_v_q && !if_go && bus.lsb_flag && !(bus.lsb_flush && bus.lsb_r_nw);
        ls_go       = use_pend || direct_take;
        cnt_inc     = cnt_q + 3'd1;
        asm_word    = rbuf_q;
        asm_word[{cnt_q[1:0], 3'b000} +: 8] = bus.mem_din;
        case (size_q)
            2'd0:    ext_word = {{24{sign_q & asm_word[7]}}, asm_word[7:0]};
            2'd1:    ext_word = {{16{sign_q & asm_word[15]}}, asm_word[15:0]};
            default: ext_word = asm_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        sign_d      = sign_q;
        size_d      = size_q;
        pend_v_d    = pend_v_q;
        pend_rnw_d  = pend_rnw_q;
        pend_sign_d = pend_sign_q;
        pend_size_d = pend_size_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        data_read_d = data_read_q;
        inst_d      = inst_q;
        data_rdy_d  = 1'b0;
        inst_rdy_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ls_go) begin
                    addr_d  = req_addr;
                    wdata_d = req_data;
                    sign_d  = req_sign;
                    size_d  = req_size;
                    n_d     = size_to_n(req_size);
                    cnt_d   = 3'd0;
                    if (req_rnw) begin
                        mem_a_d  = req_addr;
                        mem_wr_d = 1'b0;
                        state_d  = LS_RD;
                    end else if (req_addr[17:16] == IO_ADDR_HI && bus.io_buffer_full) begin
                        mem_wr_d = 1'b0;
                        state_d  = IO_WAIT;
                    end else begin
                        mem_a_d    = req_addr;
                        mem_dout_d = req_data[7:0];
                        mem_wr_d   = 1'b1;
                        state_d    = LS_WR;
                    end
                end else if (if_go) begin
                    addr_d   = bus.if_addr;
                    n_d      = 3'd4;
                    cnt_d    = 3'd0;
                    mem_a_d  = bus.if_addr;
                    mem_wr_d = 1'b0;
                    state_d  = IF_RD;
                end
            end
            IF_RD, LS_RD: begin
                if (bus.lsb_flush) begin
                    state_d = IDLE;
                end else begin
                    rbuf_d = asm_word;
                    if (cnt_inc < n_q) begin
                        cnt_d   = cnt_inc;
                        mem_a_d = addr_q + ADDR_W'(cnt_inc);
                    end else begin
                        state_d = IDLE;
                        if (state_q == IF_RD) begin
                            inst_d     = asm_word;
                            inst_rdy_d = 1'b1;
                        end else begin
                            data_read_d = ext_word;
                            data_rdy_d  = 1'b1;
                        end
                    end
                end
            end
            // Stores ignore lsb_flush: once accepted they always finish.
            LS_WR: begin
                if (cnt_inc < n_q) begin
                    cnt_d      = cnt_inc;
                    mem_a_d    = addr_q + ADDR_W'(cnt_inc);
                    mem_dout_d = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
                end else begin
                    mem_wr_d   = 1'b0;
                    data_rdy_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            IO_WAIT: begin
                if (!bus.io_buffer_full) begin
                    mem_a_d    = addr_q;
                    mem_dout_d = wdata_q[7:0];
                    mem_wr_d   = 1'b1;
                    cnt_d      = 3'd0;
                    state_d    = LS_WR;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q == IDLE && use_pend) pend_v_d = 1'b0;
        if (bus.lsb_flush && pend_rnw_q) pend_v_d = 1'b0;
        if (bus.lsb_flag && !(state_q == IDLE && direct_take) &&
            !(bus.lsb_flush && bus.lsb_r_nw)) begin
            pend_v_d    = 1'b1;
            pend_rnw_d  = bus.lsb_r_nw;
            pend_sign_d = bus.load_sign;
            pend_size_d = bus.data_size_to_mc;
            pend_addr_d = bus.data_addr;
            pend_data_d = bus.data_write;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            sign_q      <= 1'b0;
            size_q      <= '0;
            pend_v_q    <= 1'b0;
            pend_rnw_q  <= 1'b0;
            pend_sign_q <= 1'b0;
            pend_size_q <= '0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            data_read_q <= '0;
            inst_q      <= '0;
            data_rdy_q  <= 1'b0;
            inst_rdy_q  <= 1'b0;
        end else if (bus.rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            sign_q      <= sign_d;
            size_q      <= size_d;
            pend_v_q    <= pend_v_d;
            pend_rnw_q  <= pend_rnw_d;
            pend_sign_q <= pend_sign_d;
            pend_size_q <= pend_size_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            data_read_q <= data_read_d;
            inst_q      <= inst_d;
            data_rdy_q  <= data_rdy_d;
            inst_rdy_q  <= inst_rdy_d;
        end
    end

    assign bus.mem_a      = mem_a_q;
    assign bus.mem_dout   = mem_dout_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.data_read  = data_read_q;
    assign bus.inst       = inst_q;
    assign bus.data_rdy   = data_rdy_q;
    assign bus.inst_rdy   = inst_rdy_q;
    assign bus.lsb_enable = !pend_v_q && !(state_q == LS_RD || state_q == LS_WR || state_q == IO_WAIT);
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: a byte RAM model, an expected-result queue and
// one task per scenario.
module tb_memory_controller;
    localparam int ADDR_W = 32;
    localparam logic [2:0] S_IDLE = 3'd0, S_IO_WAIT = 3'd4;

    logic       clk, rst;
    logic [2:0] dbg_state;
    logic [7:0] ram [0:4095];

    memory_controller_if #(.ADDR_W(ADDR_W)) bus();

    memory_controller #(.IO_ADDR_HI(2'b11), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );

    assign bus.mem_din = ram[bus.mem_a[11:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [39:0] exp_q[$];
    logic [39:0] wr_log[$];
    logic [39:0] exp_v;
    int          drdy_at, irdy_at, drdy_cnt, irdy_cnt, wr_first;
    logic [31:0] dval, ival;
    logic [31:0] a_log [0:15];
    logic [2:0]  s_log [0:15];
    logic        en_log[0:15];

    task automatic drive_lsb(input logic rnw, input logic sgn, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] data);
        bus.lsb_flag        = 1'b1;
        bus.lsb_r_nw        = rnw;
        bus.load_sign       = sgn;
        bus.data_size_to_mc = size;
        bus.data_addr       = addr;
        bus.data_write      = data;
    endtask

    // Advances ncyc cycles, recording observations at each falling edge;
    // index i is the sample taken just after edge E_i of the accepted request.
    task automatic collect(input int ncyc, input int flush_at, input int io_rel_at);
        drdy_at = -1; irdy_at = -1; drdy_cnt = 0; irdy_cnt = 0; wr_first = -1;
        wr_log.delete();
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            bus.lsb_flag = 1'b0;
            if (bus.data_rdy) begin
                drdy_cnt++;
                if (drdy_at < 0) begin drdy_at = i; dval = bus.data_read; end
            end
            if (bus.inst_rdy) begin
                irdy_cnt++;
                if (irdy_at < 0) begin irdy_at = i; ival = bus.inst; end
                bus.if_flag = 1'b0;
            end
            if (bus.mem_wr) begin
                if (wr_first < 0) wr_first = i;
                wr_log.push_back({bus.mem_a, bus.mem_dout});
            end
            if (i < 16) begin
                a_log[i] = bus.mem_a; s_log[i] = dbg_state; en_log[i] = bus.lsb_enable;
            end
            bus.lsb_flush = (i == flush_at);
            if (i == flush_at) bus.if_flag = 1'b0;
            if (i == io_rel_at) bus.io_buffer_full = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [110:0] got;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        got = {bus.mem_a, bus.mem_dout, bus.mem_wr, bus.data_read, bus.inst,
               bus.data_rdy, bus.inst_rdy, bus.lsb_enable, dbg_state};
        n_cmp++;
        if (got !== {32'h0, 8'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, S_IDLE}) begin
            n_err++; $display("FAIL reset_outputs: got %h expected lsb_enable=1, rest 0", got);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw();
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        exp_q.push_back({8'h0, 32'h44332211});
        drive_lsb(1'b1, 1'b0, 2'd3, 32'h100, 32'h0);
        collect(8, -1, -1);
        n_cmp++; if (drdy_at !== 4) begin n_err++; $display("FAIL lw_latency: got %0d expected 4", drdy_at); end
        n_cmp++; if (drdy_cnt !== 1) begin n_err++; $display("FAIL lw_pulses: got %0d expected 1", drdy_cnt); end
        exp_v = exp_q.pop_front();
        n_cmp++; if (dval !== exp_v[31:0]) begin n_err++; $display("FAIL lw_data: got %h expected %h", dval, exp_v[31:0]); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (a_log[k] !== 32'h100 + 32'(k)) begin
                n_err++; $display("FAIL lw_addr%0d: got %h expected %h", k, a_log[k], 32'h100 + 32'(k));
            end
        end
    endtask

    task automatic test_lb_sign();
        ram[12'h008] = 8'h80;
        exp_q.push_back({8'h0, 32'hFFFFFF80});
        exp_q.push_back({8'h0, 32'h00000080});
        for (int s = 1; s >= 0; s--) begin
            drive_lsb(1'b1, s[0], 2'd0, 32'h8, 32'h0);
            collect(4, -1, -1);
            exp_v = exp_q.pop_front();
            n_cmp++; if (drdy_at !== 1) begin n_err++; $display("FAIL lb_latency_s%0d: got %0d expected 1", s, drdy_at); end
            n_cmp++; if (dval !== exp_v[31:0]) begin n_err++; $display("FAIL lb_data_s%0d: got %h expected %h", s, dval, exp_v[31:0]); end
        end
    endtask

    task automatic test_fetch_vs_lsb();
        for (int k = 0; k < 4; k++) ram[k] = 8'($urandom_range(0, 255));
        exp_q.push_back({8'h0, ram[3], ram[2], ram[1], ram[0]});
        exp_q.push_back({32'h20, 8'hEF});
        exp_q.push_back({32'h21, 8'hBE});
        bus.if_flag = 1'b1; bus.if_addr = 32'h0;
        drive_lsb(1'b0, 1'b0, 2'd1, 32'h20, 32'h1234BEEF);
        collect(12, -1, -1);
        exp_v = exp_q.pop_front();
        n_cmp++; if (irdy_at !== 4) begin n_err++; $display("FAIL fetch_latency: got %0d expected 4", irdy_at); end
        n_cmp++; if (ival !== exp_v[31:0]) begin n_err++; $display("FAIL fetch_data: got %h expected %h", ival, exp_v[31:0]); end
        n_cmp++; if (en_log[1] !== 1'b0) begin n_err++; $display("FAIL pend_enable: got %b expected 0", en_log[1]); end
        n_cmp++; if (wr_log.size() !== 2) begin n_err++; $display("FAIL sh_wr_cycles: got %0d expected 2", wr_log.size()); end
        n_cmp++; if (wr_first !== 5) begin n_err++; $display("FAIL sh_start: got %0d expected 5", wr_first); end
        for (int k = 0; k < 2; k++) begin
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (k >= wr_log.size() || wr_log[k] !== exp_v) begin
                n_err++; $display("FAIL sh_byte%0d: got %h expected %h", k, (k < wr_log.size()) ? wr_log[k] : 40'h0, exp_v);
            end
        end
        n_cmp++; if (drdy_at !== 7) begin n_err++; $display("FAIL sh_done: got %0d expected 7", drdy_at); end
    endtask

    task automatic test_io_store();
        exp_q.push_back({32'h30000, 8'h5A});
        bus.io_buffer_full = 1'b1;
        drive_lsb(1'b0, 1'b0, 2'd0, 32'h30000, 32'h0000005A);
        collect(9, -1, 4);
        n_cmp++; if (s_log[2] !== S_IO_WAIT) begin n_err++; $display("FAIL io_state: got %0d expected %0d", s_log[2], S_IO_WAIT); end
        n_cmp++; if (wr_first !== 5) begin n_err++; $display("FAIL io_wr_start: got %0d expected 5", wr_first); end
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (wr_log.size() !== 1 || wr_log[0] !== exp_v) begin
            n_err++; $display("FAIL io_byte: got %0d writes, first %h expected 1 write %h", wr_log.size(),
                              (wr_log.size() > 0) ? wr_log[0] : 40'h0, exp_v);
        end
        n_cmp++; if (drdy_at !== 6) begin n_err++; $display("FAIL io_done: got %0d expected 6", drdy_at); end
    endtask

    task automatic test_flush_reads();
        bus.if_flag = 1'b1; bus.if_addr = 32'h0;
        collect(8, 1, -1);
        n_cmp++; if (irdy_cnt !== 0) begin n_err++; $display("FAIL flush_fetch_pulse: got %0d expected 0", irdy_cnt); end
        n_cmp++;
        if (s_log[2] !== S_IDLE || en_log[2] !== 1'b1) begin
            n_err++; $display("FAIL flush_fetch_idle: got state %0d enable %b expected 0 1", s_log[2], en_log[2]);
        end
        drive_lsb(1'b1, 1'b0, 2'd3, 32'h100, 32'h0);
        collect(8, 1, -1);
        n_cmp++; if (en_log[1] !== 1'b0) begin n_err++; $display("FAIL lw_busy_enable: got %b expected 0", en_log[1]); end
        n_cmp++; if (drdy_cnt !== 0) begin n_err++; $display("FAIL flush_lw_pulse: got %0d expected 0", drdy_cnt); end
        n_cmp++;
        if (s_log[2] !== S_IDLE || en_log[2] !== 1'b1) begin
            n_err++; $display("FAIL flush_lw_idle: got state %0d enable %b expected 0 1", s_log[2], en_log[2]);
        end
    endtask

    task automatic test_flush_store();
        logic [31:0] w;
        w = 32'hCAFEF00D;
        for (int k = 0; k < 4; k++) exp_q.push_back({32'h40 + 32'(k), w[8*k +: 8]});
        drive_lsb(1'b0, 1'b0, 2'd3, 32'h40, w);
        collect(8, 1, -1);
        n_cmp++; if (wr_log.size() !== 4) begin n_err++; $display("FAIL sw_flush_count: got %0d expected 4", wr_log.size()); end
        for (int k = 0; k < 4; k++) begin
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (k >= wr_log.size() || wr_log[k] !== exp_v) begin
                n_err++; $display("FAIL sw_flush_byte%0d: got %h expected %h", k, (k < wr_log.size()) ? wr_log[k] : 40'h0, exp_v);
            end
        end
        n_cmp++; if (drdy_at !== 4 || drdy_cnt !== 1) begin n_err++; $display("FAIL sw_flush_done: got at %0d count %0d expected at 4 count 1", drdy_at, drdy_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, e;
        ram[12'h010] = 8'h34; ram[12'h011] = 8'hA5;
        exp_q.push_back({8'h0, 32'hFFFFA534});
        exp_q.push_back({8'h0, 32'h0000A534});
        drive_lsb(1'b1, 1'b1, 2'd1, 32'h10, 32'h0);
        collect(3, -1, -1);
        exp_v = exp_q.pop_front();
        n_cmp++; if (drdy_at !== 2 || dval !== exp_v[31:0]) begin n_err++; $display("FAIL lh_signed: got %h at %0d expected %h at 2", dval, drdy_at, exp_v[31:0]); end
        drive_lsb(1'b1, 1'b0, 2'd1, 32'h10, 32'h0);
        collect(4, -1, -1);
        exp_v = exp_q.pop_front();
        n_cmp++; if (drdy_at !== 2 || dval !== exp_v[31:0]) begin n_err++; $display("FAIL lhu_b2b: got %h at %0d expected %h at 2", dval, drdy_at, exp_v[31:0]); end
        a = 32'($urandom_range(12'h200, 12'h2F0)) | 32'h1;
        for (int k = 0; k < 4; k++) ram[a[11:0] + 12'(k)] = 8'($urandom_range(0, 255));
        e = {ram[a[11:0] + 12'd3], ram[a[11:0] + 12'd2], ram[a[11:0] + 12'd1], ram[a[11:0]]};
        exp_q.push_back({8'h0, e});
        drive_lsb(1'b1, 1'b1, 2'd2, a, 32'h0);
        collect(6, -1, -1);
        exp_v = exp_q.pop_front();
        n_cmp++; if (drdy_at !== 4 || dval !== exp_v[31:0]) begin n_err++; $display("FAIL size2_word: got %h at %0d expected %h at 4", dval, drdy_at, exp_v[31:0]); end
    endtask

    task automatic test_reset_mid();
        logic [110:0] got;
        drive_lsb(1'b1, 1'b0, 2'd3, 32'h100, 32'h0);
        collect(2, -1, -1);
        #1 rst = 1'b0;
        #1;
        got = {bus.mem_a, bus.mem_dout, bus.mem_wr, bus.data_read, bus.inst,
               bus.data_rdy, bus.inst_rdy, bus.lsb_enable, dbg_state};
        n_cmp++;
        if (got !== {32'h0, 8'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, S_IDLE}) begin
            n_err++; $display("FAIL midreset_outputs: got %h expected lsb_enable=1, rest 0", got);
        end
        @(negedge clk);
        rst = 1'b1;
        collect(6, -1, -1);
        n_cmp++; if (drdy_cnt !== 0) begin n_err++; $display("FAIL midreset_pulse: got %0d expected 0", drdy_cnt); end
        exp_q.push_back({8'h0, 32'h44332211});
        drive_lsb(1'b1, 1'b0, 2'd3, 32'h100, 32'h0);
        collect(6, -1, -1);
        exp_v = exp_q.pop_front();
        n_cmp++; if (drdy_at !== 4 || dval !== exp_v[31:0]) begin n_err++; $display("FAIL resume_lw: got %h at %0d expected %h at 4", dval, drdy_at, exp_v[31:0]); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        rst = 1'b0;
        bus.rdy = 1'b1; bus.io_buffer_full = 1'b0; bus.lsb_flag = 1'b0; bus.lsb_r_nw = 1'b0;
        bus.load_sign = 1'b0; bus.data_size_to_mc = 2'd0; bus.data_addr = '0; bus.data_write = '0;
        bus.if_flag = 1'b0; bus.if_addr = '0; bus.lsb_flush = 1'b0;
        test_reset();
        test_lw();
        test_lb_sign();
        test_fetch_vs_lsb();
        test_io_store();
        test_flush_reads();
        test_flush_store();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
